// File: rtl/coin_event_packer.sv
// coin_event_packer
// Packs the serial coincidence-pair event stream from the rotating bus into
// fixed OUT_WIDTH-bit frames for the readout link. The input stream has no
// backpressure. Events that arrive while the assembly frame is full and the
// output register is blocked are discarded and counted. A partial frame is
// sent after TIMEOUT idle cycles or when flush is requested.
//
// Frame layout:
//   slot k    -> [k*PAIR_DATA_WIDTH +: PAIR_DATA_WIDTH], slot 0 is the oldest
//   [OW-1:OW-3] event count
//   [OW-4:OW-8] frame sequence number (wraps)
//   unused slots and spare bits are zero
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   in_data      event from the rotating bus
//   in_en        in_data valid this cycle
//   flush        single-cycle request to send the current partial frame
//   out_data     packed frame (registered)
//   out_valid    out_data valid
//   out_ready    downstream accepts out_data this cycle
//   drop_count   saturating count of discarded events
module coin_event_packer #(
  parameter int PAIR_DATA_WIDTH  = 20,
  parameter int EVENTS_PER_FRAME = 6,
  parameter int OUT_WIDTH        = 128,
  parameter int TIMEOUT          = 255,
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PAIR_DATA_WIDTH-1:0] in_data,
  input  logic                       in_en,
  input  logic                       flush,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DROP_CNT_WIDTH-1:0]  drop_count
);

  localparam int CNT_W  = $clog2(EVENTS_PER_FRAME + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  N_CNT      = CNT_W'(EVENTS_PER_FRAME);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    SEND
  } state_t;

  logic [PAIR_DATA_WIDTH-1:0] slot_q [EVENTS_PER_FRAME];
  logic [PAIR_DATA_WIDTH-1:0] slot_d [EVENTS_PER_FRAME];
  logic [CNT_W-1:0]           asm_cnt, asm_cnt_d;
  logic [IDLE_W-1:0]          idle, idle_d;
  logic                       send_pend, send_pend_d;
  logic [4:0]                 seq, seq_d;
  logic [OUT_WIDTH-1:0]       out_data_d;
  logic                       out_valid_d;
  logic [DROP_CNT_WIDTH-1:0]  drop_d;
  logic [OUT_WIDTH-1:0]       frame;
  state_t                     state;
  logic                       xfer;

  // State is a pure decode of the registered assembly status.
  always_comb begin
    state = FILL;
    if (asm_cnt == '0)
      state = EMPTY;
    else if (asm_cnt == N_CNT || send_pend)
      state = SEND;
  end

  assign xfer = (state == SEND) && (!out_valid || out_ready);

  // Slots beyond asm_cnt may hold stale events from an earlier frame;
  // they are masked here instead of being cleared on every transfer.
  always_comb begin
    frame = '0;
    for (int unsigned k = 0; k < EVENTS_PER_FRAME; k++) begin
      if (CNT_W'(k) < asm_cnt)
        frame[k*PAIR_DATA_WIDTH +: PAIR_DATA_WIDTH] = slot_q[k];
    end
    frame[OUT_WIDTH-1 -: 3] = 3'(asm_cnt);
    frame[OUT_WIDTH-4 -: 5] = seq;
  end

  always_comb begin
    slot_d      = slot_q;
    asm_cnt_d   = asm_cnt;
    idle_d      = idle;
    send_pend_d = send_pend;
    seq_d       = seq;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    drop_d      = drop_count;

    if (out_ready)
      out_valid_d = 1'b0;

    if (state == FILL) begin
      if (!in_en) begin
        idle_d = idle + 1'b1;
        if (idle == IDLE_LAST)
          send_pend_d = 1'b1;
      end
      if (flush)
        send_pend_d = 1'b1;
    end

    if (xfer) begin
      out_data_d  = frame;
      out_valid_d = 1'b1;
      seq_d       = seq + 1'b1;
      asm_cnt_d   = '0;
      send_pend_d = 1'b0;
      idle_d      = '0;
    end

    // An event arriving in the transfer cycle starts the fresh frame.
    if (in_en) begin
      if (xfer) begin
        slot_d[0] = in_data;
        asm_cnt_d = CNT_W'(1);
      end else if (asm_cnt < N_CNT) begin
        for (int unsigned k = 0; k < EVENTS_PER_FRAME; k++) begin
          if (CNT_W'(k) == asm_cnt)
            slot_d[k] = in_data;
        end
        asm_cnt_d = asm_cnt + 1'b1;
        idle_d    = '0;
      end else if (drop_count != '1) begin
        drop_d = drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= '{default: '0};
      asm_cnt    <= '0;
      idle       <= '0;
      send_pend  <= 1'b0;
      seq        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      drop_count <= '0;
    end else begin
      slot_q     <= slot_d;
      asm_cnt    <= asm_cnt_d;
      idle       <= idle_d;
      send_pend  <= send_pend_d;
      seq        <= seq_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      drop_count <= drop_d;
    end
  end

endmodule
